// File: rtl/arm_pkg.sv
// Shared immediate-source codes, encoder FSM states and rotation helper.
// The SEARCH_INV state exists only when IMM_INVERT_EN is defined.
package arm_pkg;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam int ROT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH     = 2'd1,
`ifdef IMM_INVERT_EN
        SEARCH_INV = 2'd2,
`endif
        FIN        = 2'd3
    } state_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] w;
        w = {x, x} << amt;
        return w[63:32];
    endfunction

endpackage

// File: rtl/rot_imm_check.sv
// Tests LANES consecutive rotations starting at base_rot and reports the
// smallest one whose left-rotated data fits in eight bits.
module rot_imm_check
    import arm_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic [3:0]  base_rot,
    input  logic [31:0] data,
    output logic        hit,
    output logic [3:0]  rot,
    output logic [7:0]  imm8
);

    logic [3:0]  lane_rot;
    logic [31:0] t;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        rot      = '0;
        imm8     = '0;
        lane_rot = '0;
        t        = '0;
        // Walk from the highest lane down so the smallest matching rotation wins.
        for (int i = LANES - 1; i >= 0; i--) begin
            lane_rot = base_rot + 4'(i);
            t        = rol32(data, {lane_rot, 1'b0});
            if (t[31:8] == 24'b0) begin
                hit  = 1'b1;
                rot  = lane_rot;
                imm8 = t[7:0];
            end
        end
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Encodes a 32-bit constant into the 24-bit instruction immediate field.
// Rotated-imm mode is a multi-cycle search; IMM_INVERT_EN adds an MVN search pass.
module imm_field_encoder
    import arm_pkg::*;
#(
    parameter int ROTS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        inverted,
    output logic [23:0] ExtField
);

    localparam logic [3:0] LAST_GRP = 4'(ROT_MAX / ROTS_PER_CYCLE);

    state_t      state_q, state_d;
    logic [1:0]  src_q;
    logic [31:0] val_q;
    logic [3:0]  grp_q, grp_d;

    logic        load;
    logic        res_valid, res_inv;
    logic [23:0] res_field;

    logic [31:0] search_data;
    logic [3:0]  base_rot;
    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm8;

`ifdef IMM_INVERT_EN
    assign search_data = (state_q == SEARCH_INV) ? ~val_q : val_q;
`else
    assign search_data = val_q;
`endif
    assign base_rot = 4'(int'(grp_q) * ROTS_PER_CYCLE);
    assign busy     = (state_q != IDLE);

    rot_imm_check #(.LANES(ROTS_PER_CYCLE)) u_check (
        .base_rot (base_rot),
        .data     (search_data),
        .hit      (hit),
        .rot      (hit_rot),
        .imm8     (hit_imm8)
    );

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        load      = 1'b0;
        res_valid = 1'b0;
        res_inv   = 1'b0;
        res_field = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    grp_d   = '0;
                    state_d = (ImmSrc == IMM_DP) ? SEARCH : FIN;
                end
            end
            SEARCH: begin
                if (hit) begin
                    load      = 1'b1;
                    res_valid = 1'b1;
                    res_field = {12'b0, hit_rot, hit_imm8};
                    state_d   = IDLE;
                end else if (grp_q == LAST_GRP) begin
`ifdef IMM_INVERT_EN
                    grp_d   = '0;
                    state_d = SEARCH_INV;
`else
                    load    = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
`ifdef IMM_INVERT_EN
            SEARCH_INV: begin
                if (hit) begin
                    load      = 1'b1;
                    res_valid = 1'b1;
                    res_inv   = 1'b1;
                    res_field = {12'b0, hit_rot, hit_imm8};
                    state_d   = IDLE;
                end else if (grp_q == LAST_GRP) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
`endif
            FIN: begin
                load    = 1'b1;
                state_d = IDLE;
                case (src_q)
                    IMM_MEM: begin
                        res_valid = (val_q[31:12] == 20'b0);
                        res_field = res_valid ? {12'b0, val_q[11:0]} : 24'b0;
                    end
                    IMM_BR: begin
                        res_valid = (val_q[1:0] == 2'b00) && (val_q[31:25] == {7{val_q[25]}});
                        res_field = res_valid ? val_q[25:2] : 24'b0;
                    end
                    default: begin
                        res_valid = 1'b0;
                        res_field = '0;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            done     <= 1'b0;
            valid    <= 1'b0;
            inverted <= 1'b0;
            ExtField <= '0;
        end else begin
            state_q <= state_d;
            done    <= load;
            if (load) begin
                valid    <= res_valid;
                inverted <= res_inv;
                ExtField <= res_field;
            end
        end
    end

    // NOTE: job operands are only read while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        grp_q <= grp_d;
        if (state_q == IDLE && start) begin
            src_q <= ImmSrc;
            val_q <= Value;
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed table-driven bench for imm_field_encoder with a decode round-trip
// scoreboard, plus hand sequences for hold, ignored start and reset abort.
module tb_imm_field_encoder;

    localparam int P    = 1;
    localparam int NGRP = 16 / P;
`ifdef IMM_INVERT_EN
    localparam int FAIL_CYC = 2 * NGRP + 1;
`else
    localparam int FAIL_CYC = NGRP + 1;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        busy, done, valid, inverted;
    logic [23:0] ExtField;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] val;
        logic        exp_valid;
        logic        exp_inv;
        logic [23:0] exp_field;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    imm_field_encoder #(.ROTS_PER_CYCLE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ImmSrc   (ImmSrc),
        .Value    (Value),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .inverted (inverted),
        .ExtField (ExtField)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] s, input logic [31:0] v, input logic ev,
                                input logic ei, input logic [23:0] ef, input int ec);
        vec_t x;
        x.src = s; x.val = v; x.exp_valid = ev; x.exp_inv = ei; x.exp_field = ef; x.exp_cyc = ec;
        return x;
    endfunction

    function automatic int dp_cyc(input int r);
        return r / P + 2;
    endfunction

    function automatic logic [31:0] decode(input logic [1:0] s, input logic [23:0] f);
        logic [31:0] x;
        int sh;
        case (s)
            2'b01:   return {20'b0, f[11:0]};
            2'b10:   return {{6{f[23]}}, f, 2'b00};
            default: begin
                x  = {24'b0, f[7:0]};
                sh = 2 * int'(f[11:8]);
                return (x >> sh) | (x << (32 - sh));
            end
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raises start at the current negedge; returns at the negedge of cycle 1.
    task automatic start_job(input logic [1:0] s, input logic [31:0] v);
        start = 1'b1; ImmSrc = s; Value = v;
        next_cycle();
        start = 1'b0; ImmSrc = 2'b11; Value = 32'hDEADBEEF;
        check("busy_cycle1", busy, 1'b1);
    endtask

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 80) begin
            next_cycle();
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", done, 1'b1);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] want;

        vecs.push_back(mk(2'b00, 32'h000000FF, 1, 0, 24'h0000FF, dp_cyc(0)));
        vecs.push_back(mk(2'b00, 32'h00000000, 1, 0, 24'h000000, dp_cyc(0)));
        vecs.push_back(mk(2'b00, 32'hFF000000, 1, 0, 24'h0004FF, dp_cyc(4)));
        vecs.push_back(mk(2'b00, 32'hF000000F, 1, 0, 24'h0002FF, dp_cyc(2)));
        vecs.push_back(mk(2'b00, 32'h000003FC, 1, 0, 24'h000FFF, dp_cyc(15)));
        vecs.push_back(mk(2'b00, 32'h00000104, 1, 0, 24'h000F41, dp_cyc(15)));
        vecs.push_back(mk(2'b00, 32'h00000101, 0, 0, 24'h000000, FAIL_CYC));
`ifdef IMM_INVERT_EN
        vecs.push_back(mk(2'b00, 32'hFFFFFF00, 1, 1, 24'h0000FF, NGRP + 2));
        vecs.push_back(mk(2'b00, 32'h00FFFFFF, 1, 1, 24'h0004FF, NGRP + 2 + 4 / P));
`else
        vecs.push_back(mk(2'b00, 32'hFFFFFF00, 0, 0, 24'h000000, FAIL_CYC));
        vecs.push_back(mk(2'b00, 32'h00FFFFFF, 0, 0, 24'h000000, FAIL_CYC));
`endif
        vecs.push_back(mk(2'b01, 32'h00000FFF, 1, 0, 24'h000FFF, 2));
        vecs.push_back(mk(2'b01, 32'h00001000, 0, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b01, 32'h00000000, 1, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b10, 32'h00000006, 0, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b10, 32'h04000000, 0, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b10, 32'h01FFFFFC, 1, 0, 24'h7FFFFF, 2));
        vecs.push_back(mk(2'b10, 32'h03FFFFFC, 0, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b10, 32'hFE000000, 1, 0, 24'h800000, 2));
        vecs.push_back(mk(2'b11, 32'h000000FF, 0, 0, 24'h000000, 2));
        vecs.push_back(mk(2'b10, 32'hFFFFFFF8, 1, 0, 24'hFFFFFE, 2));

        reset = 1'b1; start = 1'b0; ImmSrc = 2'b00; Value = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_inverted", inverted, 1'b0);
        check("reset_field", ExtField, 24'h0);
        reset = 1'b0;
        next_cycle();

        // Each job is launched in the done cycle of the previous one.
        foreach (vecs[i]) begin
            start_job(vecs[i].src, vecs[i].val);
            cyc = 1;
            wait_done(cyc);
            check($sformatf("v%0d_cycle", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
            check($sformatf("v%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("v%0d_inverted", i), inverted, vecs[i].exp_inv);
            check($sformatf("v%0d_field", i), ExtField, vecs[i].exp_field);
            if (valid === 1'b1) begin
                want = inverted ? ~vecs[i].val : vecs[i].val;
                check($sformatf("v%0d_roundtrip", i), decode(vecs[i].src, ExtField), want);
            end
        end

        // Results hold while idle and are not cleared by a new start.
        repeat (3) next_cycle();
        check("hold_idle_valid", valid, 1'b1);
        check("hold_idle_field", ExtField, 24'hFFFFFE);
        check("hold_done_low", done, 1'b0);
        start_job(2'b00, 32'h00000101);
        check("hold_start_valid", valid, 1'b1);
        check("hold_start_field", ExtField, 24'hFFFFFE);

        // A start raised mid-search is dropped.
        next_cycle();
        next_cycle();
        start = 1'b1; ImmSrc = 2'b01; Value = 32'h00000FFF;
        next_cycle();
        start = 1'b0;
        cyc = 4;
        wait_done(cyc);
        check("ignore_cycle", cyc, FAIL_CYC);
        check("ignore_valid", valid, 1'b0);
        check("ignore_field", ExtField, 24'h0);
        pulses = 0;
        repeat (5) begin
            next_cycle();
            if (done === 1'b1) pulses++;
        end
        check("ignore_no_second_done", pulses, 0);

        // Reset mid-search aborts with no done pulse and cleared outputs.
        start_job(2'b00, 32'h000000FF);
        cyc = 1;
        wait_done(cyc);
        check("pre_abort_valid", valid, 1'b1);
        next_cycle();
        start_job(2'b00, 32'h00000101);
        repeat (4) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        check("abort_inverted", inverted, 1'b0);
        check("abort_field", ExtField, 24'h0);
        pulses = (done === 1'b1) ? 1 : 0;
        repeat (20) begin
            next_cycle();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);

        start_job(2'b00, 32'hFF000000);
        cyc = 1;
        wait_done(cyc);
        check("post_abort_cycle", cyc, dp_cyc(4));
        check("post_abort_field", ExtField, 24'h0004FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
